instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit directly upstream of the control/decode stage. Issues word reads to instruction memory from a running fetch PC and buffers returned words with their PCs in a small FIFO. Hands instructions to decode over a valid/ready handshake. Supports a redirect (jump/branch) that flushes the buffer and any in-flight read.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset; word-aligned
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req_valid  out  1  read request pending
- mem_req_addr  out  32  byte address of the request; bits [1:0] always 0
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_resp_valid  in  1  read data returned this cycle
- mem_resp_data  in  32  instruction word
- instr_valid  out  1  FIFO head holds an instruction
- instr  out  32  FIFO head instruction word
- instr_pc  out  32  byte address of instr
- instr_ready  in  1  decode consumes the head this cycle
- redirect  in  1  flush and restart fetching at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0

## Operation
- Registers: fetch_pc (32), FIFO storage of {pc, word} × DEPTH, rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), discard flag.
- FSM states: REQ, WAIT. At most one read outstanding.
- REQ: mem_req_valid = 1 iff count + 0 < DEPTH (space must be reserved for the response); mem_req_addr = fetch_pc. On valid && ready: fetch_pc += 4 (wraps at 2^32), go to WAIT.
- WAIT: mem_req_valid = 0. On mem_resp_valid: if discard = 0, push {request pc, mem_resp_data}; clear discard; go to REQ. Request pc is latched at acceptance.
- Pop: instr_valid && instr_ready removes the head; instr/instr_pc come from storage, no combinational path from mem_resp_data.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Redirect (highest priority):
  - count ← 0, pointers ← 0, fetch_pc ← {redirect_pc[31:2], 2'b00}; any pop that cycle is ignored.
  - If in WAIT without a response this cycle, or if a request is accepted this same cycle: discard ← 1, so the stale response is dropped.
  - A response arriving in the redirect cycle is dropped.
  - If a request is pending in REQ but not accepted, the address changes to the redirect target next cycle. The memory tolerates this.
- mem_resp_valid in REQ with no outstanding read is a protocol error: ignored, no push.
- Reset (any time, mid-transaction included): state REQ, fetch_pc = RESET_PC, count = 0, pointers = 0, discard = 0.

## Timing
- Reset values: mem_req_valid 0 while rst high, then 1 in the first cycle after release; mem_req_addr = RESET_PC; instr_valid 0; instr 0; instr_pc 0.
- Response in cycle N (not discarded): instr_valid = 1 from cycle N+1.
- Next request is asserted in cycle N+1 if space is available.
- Zero-wait memory (ready=1, response one cycle after acceptance): one instruction every 2 cycles.
- Full: count = DEPTH → mem_req_valid 0. It re-asserts the cycle after the first pop.
- Empty: instr_valid 0. instr/instr_pc hold the last values and must not be relied upon.
- Redirect in cycle R: instr_valid 0 in R+1.
  - First new request in R+1 if no read is outstanding.
  - Otherwise it follows the discarded response.

## Test plan
- Reset release, ready=1, response 1 cycle later with words 0x0000_0013, 0x0010_0093, instr_ready=1 → requests at 0x0, 0x4; instr/instr_pc pairs (0x13, 0x0), (0x00100093, 0x4) in order.
- instr_ready=0, DEPTH=2 → after 2 responses, mem_req_valid stays 0 with addr 0x8. One pop → request at 0x8 next cycle.
- Redirect to 0x0000_0103 while in WAIT → response word 0xDEAD_BEEF dropped, FIFO empty, next request addr 0x100, first delivered instr_pc 0x100.
- Redirect in the same cycle as a push and a pop → count 0, instr_valid 0 next cycle, the response word is not delivered.
- mem_req_ready held 0 for 5 cycles → mem_req_valid held 1 with addr stable at 0x4. Redirect to 0x40 mid-stall → addr 0x40 next cycle.
- rst asserted mid-WAIT → all outputs at reset values immediately. After release, request at RESET_PC; a late response is ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory, decode hand-off and redirect signals of the fetch unit
interface instr_fetch_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch unit: one outstanding word read, {pc, word} FIFO to decode, redirect flush
module instr_fetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_word_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_discard;
  logic          r_req_valid;
  logic          r_instr_valid;

  logic          w_req_fire;
  logic          w_resp_take;
  logic          w_push;
  logic          w_pop;
  state_t        w_state_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_discard_nxt;
  logic [31:0]   w_fetch_pc_nxt;

  assign w_req_fire  = r_req_valid && bus.mem_req_ready;
  assign w_resp_take = (r_state == S_WAIT) && bus.mem_resp_valid;
  assign w_push      = w_resp_take && !r_discard && !bus.redirect;
  assign w_pop       = r_instr_valid && bus.instr_ready && !bus.redirect;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_req_fire)  w_state_nxt = S_WAIT;
      S_WAIT:  if (w_resp_take) w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (bus.redirect)
      w_count_nxt = '0;
    else if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  // A redirect leaves a read in flight when it lands in WAIT without data or on an accept.
  always_comb begin
    w_discard_nxt = r_discard;
    if (bus.redirect)
      w_discard_nxt = ((r_state == S_WAIT) && !bus.mem_resp_valid) || w_req_fire;
    else if (w_resp_take)
      w_discard_nxt = 1'b0;
  end

  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    if (bus.redirect)
      w_fetch_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
    else if (w_req_fire)
      w_fetch_pc_nxt = r_fetch_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_discard     <= 1'b0;
      r_req_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_pc_mem[i]   <= '0;
        r_word_mem[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_count    <= w_count_nxt;
      r_discard  <= w_discard_nxt;
      if (w_req_fire)
        r_req_pc <= r_fetch_pc;
      if (w_push) begin
        r_pc_mem[r_wr_ptr]   <= r_req_pc;
        r_word_mem[r_wr_ptr] <= bus.mem_resp_data;
      end
      if (bus.redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      // Request needs a free slot reserved for its response.
      r_req_valid   <= (w_state_nxt == S_REQ) && (w_count_nxt < FULL);
      r_instr_valid <= (w_count_nxt != '0);
    end
  end

  assign bus.mem_req_valid = r_req_valid;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign bus.instr_valid   = r_instr_valid;
  assign bus.instr         = r_word_mem[r_rd_ptr];
  assign bus.instr_pc      = r_pc_mem[r_rd_ptr];
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized checks of instr_fetch against a stream model
module tb_instr_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch_if bif ();

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wordof(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] d,
                       input logic ir, input logic rd, input logic [31:0] rpc);
    bif.mem_req_ready  = rdy;
    bif.mem_resp_valid = rv;
    bif.mem_resp_data  = d;
    bif.instr_ready    = ir;
    bif.redirect       = rd;
    bif.redirect_pc    = rpc;
    @(negedge clk);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] paddr;
  logic [31:0] r_d;
  logic [31:0] r_rpc;
  logic        r_rdy, r_rv, r_ir, r_rd, r_acc;
  int          busy;
  int          cnt;
  int          delivered;

  initial begin
    bif.mem_req_ready  = 1'b0;
    bif.mem_resp_valid = 1'b0;
    bif.mem_resp_data  = '0;
    bif.instr_ready    = 1'b0;
    bif.redirect       = 1'b0;
    bif.redirect_pc    = '0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_req_valid", 32'(bif.mem_req_valid), 0);
    chk("rst_req_addr", bif.mem_req_addr, RESET_PC);
    chk("rst_instr_valid", 32'(bif.instr_valid), 0);
    chk("rst_instr", bif.instr, 0);
    chk("rst_instr_pc", bif.instr_pc, 0);

    // basic fetch at zero-wait memory
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("t1_req0_valid", 32'(bif.mem_req_valid), 1);
    chk("t1_req0_addr", bif.mem_req_addr, 32'h0);
    drive(1, 0, 0, 1, 0, 0);
    chk("t1_wait_valid", 32'(bif.mem_req_valid), 0);
    drive(0, 1, 32'h0000_0013, 0, 0, 0);
    chk("t1_i0_valid", 32'(bif.instr_valid), 1);
    chk("t1_i0_word", bif.instr, 32'h0000_0013);
    chk("t1_i0_pc", bif.instr_pc, 32'h0);
    chk("t1_req1_addr", bif.mem_req_addr, 32'h4);
    chk("t1_req1_valid", 32'(bif.mem_req_valid), 1);
    drive(1, 0, 0, 1, 0, 0);
    chk("t1_pop_empty", 32'(bif.instr_valid), 0);
    drive(0, 1, 32'h0010_0093, 0, 0, 0);
    chk("t1_i1_word", bif.instr, 32'h0010_0093);
    chk("t1_i1_pc", bif.instr_pc, 32'h4);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0);
    chk("t2_restart_valid", 32'(bif.mem_req_valid), 1);
    chk("t2_restart_addr", bif.mem_req_addr, 32'h0);

    // fill the FIFO with decode stalled
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, wordof(32'h0), 0, 0, 0);
    chk("t2_req4_addr", bif.mem_req_addr, 32'h4);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, wordof(32'h4), 0, 0, 0);
    chk("t2_full_valid", 32'(bif.mem_req_valid), 0);
    chk("t2_full_addr", bif.mem_req_addr, 32'h8);
    chk("t2_head_pc", bif.instr_pc, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t2_full_hold", 32'(bif.mem_req_valid), 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("t2_after_pop_valid", 32'(bif.mem_req_valid), 1);
    chk("t2_after_pop_addr", bif.mem_req_addr, 32'h8);
    chk("t2_after_pop_pc", bif.instr_pc, 32'h4);

    // redirect while a read is outstanding
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0000_0103);
    chk("t3_flush_ivalid", 32'(bif.instr_valid), 0);
    chk("t3_wait_valid", 32'(bif.mem_req_valid), 0);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("t3_stale_dropped", 32'(bif.instr_valid), 0);
    chk("t3_new_valid", 32'(bif.mem_req_valid), 1);
    chk("t3_new_addr", bif.mem_req_addr, 32'h100);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, wordof(32'h100), 0, 0, 0);
    chk("t3_first_pc", bif.instr_pc, 32'h100);
    chk("t3_first_word", bif.instr, wordof(32'h100));

    // redirect coinciding with push and pop
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'hCAFE_F00D, 1, 1, 32'h200);
    chk("t4_ivalid", 32'(bif.instr_valid), 0);
    chk("t4_req_addr", bif.mem_req_addr, 32'h200);
    chk("t4_req_valid", 32'(bif.mem_req_valid), 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("t4_not_delivered", 32'(bif.instr_valid), 0);

    // request stalled by memory, then retargeted
    drive(0, 0, 0, 0, 1, 32'h4);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("t5_stall_valid", 32'(bif.mem_req_valid), 1);
      chk("t5_stall_addr", bif.mem_req_addr, 32'h4);
    end
    drive(0, 0, 0, 0, 1, 32'h40);
    chk("t5_retarget_addr", bif.mem_req_addr, 32'h40);
    chk("t5_retarget_valid", 32'(bif.mem_req_valid), 1);

    // asynchronous reset in the middle of a read
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, wordof(32'h40), 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("t6_pre_ivalid", 32'(bif.instr_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_async_req_valid", 32'(bif.mem_req_valid), 0);
    chk("t6_async_addr", bif.mem_req_addr, RESET_PC);
    chk("t6_async_ivalid", 32'(bif.instr_valid), 0);
    chk("t6_async_instr", bif.instr, 0);
    chk("t6_async_pc", bif.instr_pc, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 1, 32'hBADC_0DE5, 0, 0, 0);
    chk("t6_late_ignored", 32'(bif.instr_valid), 0);
    chk("t6_req_valid", 32'(bif.mem_req_valid), 1);
    chk("t6_req_addr", bif.mem_req_addr, RESET_PC);
    drive(0, 0, 0, 0, 0, 0);
    chk("t6_late_still_ignored", 32'(bif.instr_valid), 0);

    // random traffic: delivered stream must be consecutive words from the last redirect target
    exp_pc    = RESET_PC;
    busy      = 0;
    cnt       = 0;
    delivered = 0;
    paddr     = '0;
    for (int k = 0; k < 3000; k++) begin
      if (bif.mem_req_valid) begin
        chk("rand_one_outstanding", 32'(busy), 0);
        chk("rand_addr_align", 32'(bif.mem_req_addr[1:0]), 0);
      end
      r_rv  = (busy != 0) && (cnt == 0);
      r_d   = r_rv ? wordof(paddr) : $urandom;
      r_rdy = ($urandom_range(0, 3) != 0);
      r_ir  = ($urandom_range(0, 2) != 0);
      r_rd  = ($urandom_range(0, 39) == 0);
      r_rpc = $urandom & 32'h0000_0FFF;
      if (bif.instr_valid && r_ir && !r_rd) begin
        chk("rand_pc", bif.instr_pc, exp_pc);
        chk("rand_word", bif.instr, wordof(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (r_rd)
        exp_pc = r_rpc & 32'hFFFF_FFFC;
      r_acc = bif.mem_req_valid && r_rdy;
      if (r_rv)
        busy = 0;
      else if (busy != 0)
        cnt--;
      if (r_acc) begin
        busy  = 1;
        paddr = bif.mem_req_addr;
        cnt   = int'($urandom_range(0, 2));
      end
      drive(r_rdy, r_rv, r_d, r_ir, r_rd, r_rpc);
    end
    chk("rand_progress", 32'(delivered > 200), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
